mips_mc_controller: RTL and testbench
=====================================

MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 SHALL have parameter ENABLE_BNE, default 1, which enables bne (op 000101) decoding.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-004 SHALL have port op  input  6  opcode from the instruction register.
REQ-005 SHALL have port funct  input  6  R-type function field.
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have ports MemtoReg, RegDst, IorD, ALUSrcA  output  1 each  datapath mux selects.
REQ-008 SHALL have ports PCSrc, ALUSrcB  output  2 each  datapath mux selects.
REQ-009 SHALL have ports IRWrite, MemWrite, RegWrite  output  1 each  write enables.
REQ-010 SHALL have port PCEn  output  1  PC register enable.
REQ-011 SHALL have port ALUControl  output  3  ALU operation.
REQ-012 SHALL have port state  output  4  current FSM state (debug).
REQ-013 SHALL have port instr_done  output  1  one-cycle pulse in the final state of each instruction.

Function
REQ-014 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
REQ-015 SHALL transition FETCH->DECODE unconditionally.
REQ-016 SHALL transition from DECODE to: MEMADR for lw 100011 or sw 101011; EXECUTE for 000000; BRANCH for beq 000100 (and for bne if ENABLE_BNE); ADDIEXEC for addi 001000; JUMP for j 000010; FETCH for any other op.
REQ-017 SHALL transition MEMADR->MEMRD for lw and MEMADR->MEMWR otherwise; MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEXEC->ADDIWB; MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP -> FETCH.
REQ-018 SHALL drive FETCH outputs as IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1.
REQ-019 SHALL drive DECODE outputs as ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-020 SHALL drive MEMADR and ADDIEXEC outputs as ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-021 SHALL drive MEMRD as IorD=1, and MEMWR as IorD=1, MemWrite=1.
REQ-022 SHALL drive MEMWB as MemtoReg=1, RegDst=0, RegWrite=1; ALUWB as RegDst=1, RegWrite=1; ADDIWB as RegDst=0, MemtoReg=0, RegWrite=1.
REQ-023 SHALL drive EXECUTE as ALUSrcA=1, ALUSrcB=00, ALUOp=10.
REQ-024 SHALL drive BRANCH as ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, with Branch=1 for beq or BranchNe=1 for bne.
REQ-025 SHALL drive JUMP as PCSrc=10, PCWrite=1.
REQ-026 SHALL drive every output not listed for a state to 0.
REQ-027 SHALL drive PCEn = PCWrite | (Branch & zero) | (BranchNe & ~zero), combinationally, in the same cycle as zero.
REQ-028 SHALL map ALUControl as ALUOp 00->010 and 01->110; for 10, funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct->010.
REQ-029 SHALL assert instr_done in MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP, and in DECODE when op is unrecognised.
REQ-030 SHALL give latencies of lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, and unknown op 2 cycles.

Reset
REQ-031 SHALL force state to FETCH on any rising edge with reset=0, including mid-instruction.
REQ-032 SHALL force IRWrite, MemWrite, RegWrite, PCEn and instr_done to 0 while reset=0, with all other outputs at their FETCH values.

Structure
REQ-033 SHALL place the state enum (4-bit encoding), opcode/funct constants, ALUOp and ALUControl encodings in package mips_pkg.
REQ-034 SHALL implement the ALU decode in sub-module alu_decoder (inputs ALUOp[1:0] and funct[5:0]; output ALUControl[2:0]).

Verification
REQ-035 SHALL cover op=100011 after reset: states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 and MemtoReg=1 only in MEMWB; instr_done on cycle 5.
REQ-036 SHALL cover op=000000, funct=101010: ALUControl=111 in EXECUTE; RegDst=1, RegWrite=1 in ALUWB.
REQ-037 SHALL cover beq with zero=1 -> PCEn=1 in BRANCH; beq with zero=0 -> PCEn=0; bne with zero=0 -> PCEn=1.
REQ-038 SHALL cover op=111111 -> DECODE->FETCH; no write enable asserted in DECODE; instr_done=1 in DECODE.
REQ-039 SHALL cover reset=0 during MEMWR -> state=FETCH next edge; MemWrite=0 and PCEn=0 while reset=0.
REQ-040 SHALL cover ENABLE_BNE=0 with op=000101 -> DECODE->FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller.
//   state_t   : 4-bit FSM state encoding (also exported on the debug port)
//   OP_*      : opcode values recognised by the decoder
//   FN_*      : R-type funct values understood by the ALU decoder
//   ALUOP_*   : controller-to-ALU-decoder operation class
//   ALUCTL_*  : ALU operation codes driven to the datapath
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: turns the controller's ALUOp class plus the R-type funct
// field into the 3-bit ALU operation.
//   ALUOp      in  [1:0] operation class (add / subtract / use funct)
//   funct      in  [5:0] R-type function field
//   ALUControl out [2:0] ALU operation code
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALUCTL_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALUCTL_ADD;
      ALUOP_SUB: ALUControl = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  ALUControl = ALUCTL_ADD;
          FN_SUB:  ALUControl = ALUCTL_SUB;
          FN_AND:  ALUControl = ALUCTL_AND;
          FN_OR:   ALUControl = ALUCTL_OR;
          FN_SLT:  ALUControl = ALUCTL_SLT;
          default: ALUControl = ALUCTL_ADD;
        endcase
      end
      // Unused class 11 falls back to add.
      default: ALUControl = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode and the
// per-instruction execute/writeback steps, plus the ALU decoder.
//   clk, reset          in  clock; synchronous active-low reset
//   op, funct, zero     in  opcode, R-type funct, ALU zero flag
//   MemtoReg, RegDst,
//   IorD, ALUSrcA       out 1-bit datapath mux selects
//   PCSrc, ALUSrcB      out 2-bit datapath mux selects
//   IRWrite, MemWrite,
//   RegWrite, PCEn      out write enables
//   ALUControl          out ALU operation
//   state               out current FSM state (debug)
//   instr_done          out pulse in the last cycle of each instruction
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int ENABLE_BNE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUSrcB,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCEn,
  output logic [2:0] ALUControl,
  output logic [3:0] state,
  output logic       instr_done
);

  localparam bit BneEn = (ENABLE_BNE != 0);

  state_t     state_q, state_d;
  state_t     cur_state;
  logic       is_bne, op_known;
  logic       ir_write, mem_write, reg_write, pc_write;
  logic       branch, branch_ne, done;
  logic [1:0] alu_op;

  assign is_bne   = BneEn && (op == OP_BNE);
  assign op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                    (op == OP_BEQ) || is_bne || (op == OP_ADDI) || (op == OP_J);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if ((op == OP_LW) || (op == OP_SW))     state_d = S_MEMADR;
        else if (op == OP_RTYPE)                state_d = S_EXECUTE;
        else if ((op == OP_BEQ) || is_bne)      state_d = S_BRANCH;
        else if (op == OP_ADDI)                 state_d = S_ADDIEXEC;
        else if (op == OP_J)                    state_d = S_JUMP;
        else                                    state_d = S_FETCH;
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // While reset is held the outputs show the FETCH decode; the write enables
  // are masked separately below so nothing is committed during reset.
  assign cur_state = reset ? state_q : S_FETCH;

  always_comb begin
    MemtoReg  = 1'b0;
    RegDst    = 1'b0;
    IorD      = 1'b0;
    ALUSrcA   = 1'b0;
    PCSrc     = 2'b00;
    ALUSrcB   = 2'b00;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    alu_op    = ALUOP_ADD;
    done      = 1'b0;
    case (cur_state)
      S_FETCH: begin
        ALUSrcB  = 2'b01;
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        // Unrecognised opcodes retire straight out of decode.
        done    = !op_known;
      end
      S_MEMADR, S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWR: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
        done      = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg  = 1'b1;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst    = 1'b1;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        alu_op    = ALUOP_SUB;
        PCSrc     = 2'b01;
        branch    = (op == OP_BEQ);
        branch_ne = is_bne;
        done      = 1'b1;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign IRWrite    = reset & ir_write;
  assign MemWrite   = reset & mem_write;
  assign RegWrite   = reset & reg_write;
  assign instr_done = reset & done;
  // Branch resolution uses the zero flag of the same cycle.
  assign PCEn       = reset & (pc_write | (branch & zero) | (branch_ne & ~zero));
  assign state      = cur_state;

  alu_decoder u_alu_decoder (
    .ALUOp      (alu_op),
    .funct      (funct),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_mips_mc_controller.sv
module tb_mips_mc_controller;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = OP_LW;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;

  logic       d1_MemtoReg, d1_RegDst, d1_IorD, d1_ALUSrcA;
  logic [1:0] d1_PCSrc, d1_ALUSrcB;
  logic       d1_IRWrite, d1_MemWrite, d1_RegWrite, d1_PCEn, d1_done;
  logic [2:0] d1_ALUControl;
  logic [3:0] d1_state;
  logic       d0_MemtoReg, d0_RegDst, d0_IorD, d0_ALUSrcA;
  logic [1:0] d0_PCSrc, d0_ALUSrcB;
  logic       d0_IRWrite, d0_MemWrite, d0_RegWrite, d0_PCEn, d0_done;
  logic [2:0] d0_ALUControl;
  logic [3:0] d0_state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int pos0 = 0;
  int pos1 = 0;
  logic [13:0] ctl_tab [12];
  logic [19:0] g0, g1, e0, e1;

  always #5 clk = ~clk;

  mips_mc_controller #(.ENABLE_BNE(1)) dut1 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .MemtoReg(d1_MemtoReg), .RegDst(d1_RegDst), .IorD(d1_IorD), .ALUSrcA(d1_ALUSrcA),
    .PCSrc(d1_PCSrc), .ALUSrcB(d1_ALUSrcB), .IRWrite(d1_IRWrite), .MemWrite(d1_MemWrite),
    .RegWrite(d1_RegWrite), .PCEn(d1_PCEn), .ALUControl(d1_ALUControl), .state(d1_state),
    .instr_done(d1_done));

  mips_mc_controller #(.ENABLE_BNE(0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .MemtoReg(d0_MemtoReg), .RegDst(d0_RegDst), .IorD(d0_IorD), .ALUSrcA(d0_ALUSrcA),
    .PCSrc(d0_PCSrc), .ALUSrcB(d0_ALUSrcB), .IRWrite(d0_IRWrite), .MemWrite(d0_MemWrite),
    .RegWrite(d0_RegWrite), .PCEn(d0_PCEn), .ALUControl(d0_ALUControl), .state(d0_state),
    .instr_done(d0_done));

  // Control word per state: MemtoReg RegDst IorD ALUSrcA PCSrc[2] ALUSrcB[2]
  //                         IRWrite MemWrite RegWrite PCWrite ALUOp[2]
  initial begin
    ctl_tab[0]  = 14'b0000_00_01_1001_00; // FETCH
    ctl_tab[1]  = 14'b0000_00_11_0000_00; // DECODE
    ctl_tab[2]  = 14'b0001_00_10_0000_00; // MEMADR
    ctl_tab[3]  = 14'b0010_00_00_0000_00; // MEMRD
    ctl_tab[4]  = 14'b1000_00_00_0010_00; // MEMWB
    ctl_tab[5]  = 14'b0010_00_00_0100_00; // MEMWR
    ctl_tab[6]  = 14'b0001_00_00_0000_10; // EXECUTE
    ctl_tab[7]  = 14'b0100_00_00_0010_00; // ALUWB
    ctl_tab[8]  = 14'b0001_01_00_0000_01; // BRANCH
    ctl_tab[9]  = 14'b0001_00_10_0000_00; // ADDIEXEC
    ctl_tab[10] = 14'b0000_00_00_0010_00; // ADDIWB
    ctl_tab[11] = 14'b0000_10_00_0001_00; // JUMP
  end

  // Number of cycles an instruction occupies.
  function automatic int ilen(logic [5:0] o, bit en);
    if (o == OP_LW) return 5;
    if (o == OP_SW || o == OP_RTYPE || o == OP_ADDI) return 4;
    if (o == OP_BEQ || o == OP_J) return 3;
    if (o == OP_BNE) return en ? 3 : 2;
    return 2;
  endfunction

  // State visited in cycle p of an instruction.
  function automatic int st_at(logic [5:0] o, int p);
    if (p == 0) return 0;
    if (p == 1) return 1;
    if (o == OP_LW) return (p == 2) ? 2 : (p == 3) ? 3 : 4;
    if (o == OP_SW) return (p == 2) ? 2 : 5;
    if (o == OP_RTYPE) return (p == 2) ? 6 : 7;
    if (o == OP_ADDI) return (p == 2) ? 9 : 10;
    if (o == OP_J) return 11;
    return 8;
  endfunction

  function automatic logic [2:0] alu_ref(logic [1:0] aop, logic [5:0] f);
    if (aop == 2'b01) return 3'b110;
    if (aop != 2'b10) return 3'b010;
    if (f == 6'b100010) return 3'b110;
    if (f == 6'b100100) return 3'b000;
    if (f == 6'b100101) return 3'b001;
    if (f == 6'b101010) return 3'b111;
    return 3'b010;
  endfunction

  function automatic logic [19:0] exp_out(int p, bit en, logic rst, logic [5:0] o,
                                          logic [5:0] f, logic z);
    int st;
    logic [13:0] c;
    logic pcen, dn;
    if (!rst) return {4'd0, 8'b0000_0001, 3'b000, 1'b0, 3'b010, 1'b0};
    st = st_at(o, p);
    c = ctl_tab[st];
    pcen = c[2] | ((st == 8) & (((o == OP_BEQ) & z) | (en & (o == OP_BNE) & ~z)));
    dn = (p == ilen(o, en) - 1);
    return {st[3:0], c[13:6], c[5:3], pcen, alu_ref(c[1:0], f), dn};
  endfunction

  always @(posedge clk) begin
    pos1 <= (!reset || pos1 == ilen(op, 1'b1) - 1) ? 0 : pos1 + 1;
    pos0 <= (!reset || pos0 == ilen(op, 1'b0) - 1) ? 0 : pos0 + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      g1 = {d1_state, d1_MemtoReg, d1_RegDst, d1_IorD, d1_ALUSrcA, d1_PCSrc, d1_ALUSrcB,
            d1_IRWrite, d1_MemWrite, d1_RegWrite, d1_PCEn, d1_ALUControl, d1_done};
      g0 = {d0_state, d0_MemtoReg, d0_RegDst, d0_IorD, d0_ALUSrcA, d0_PCSrc, d0_ALUSrcB,
            d0_IRWrite, d0_MemWrite, d0_RegWrite, d0_PCEn, d0_ALUControl, d0_done};
      e1 = exp_out(pos1, 1'b1, reset, op, funct, zero);
      e0 = exp_out(pos0, 1'b0, reset, op, funct, zero);
      checks++;
      if (g1 !== e1) begin
        errors++;
        $display("FAIL model_bne1 t=%0t op=%b got %h expected %h", $time, op, g1, e1);
      end
      checks++;
      if (g0 !== e0) begin
        errors++;
        $display("FAIL model_bne0 t=%0t op=%b got %h expected %h", $time, op, g0, e0);
      end
    end
  end

  task automatic chk(string nm, logic [7:0] got, logic [7:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, expv);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  logic [5:0] op_tab [7];
  logic [5:0] fn_tab [5];

  initial begin
    op_tab = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
    fn_tab = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    @(posedge clk);
    chk_en = 1'b1;

    // reset held low
    cyc(); #1;
    chk("rst_state", 8'(d1_state), 8'd0);
    chk("rst_irwrite", 8'(d1_IRWrite), 8'd0);
    chk("rst_pcen", 8'(d1_PCEn), 8'd0);
    chk("rst_done", 8'(d1_done), 8'd0);
    chk("rst_alusrcb", 8'(d1_ALUSrcB), 8'd1);
    reset = 1'b1; #1;
    chk("lw_fetch_ir", 8'(d1_IRWrite), 8'd1);
    chk("lw_fetch_pcen", 8'(d1_PCEn), 8'd1);
    cyc(); #1; chk("lw_decode", 8'(d1_state), 8'd1);
    cyc(); #1; chk("lw_memadr", 8'(d1_state), 8'd2);
    chk("lw_memadr_rw", 8'(d1_RegWrite), 8'd0);
    cyc(); #1; chk("lw_memrd", 8'(d1_state), 8'd3);
    chk("lw_memrd_done", 8'(d1_done), 8'd0);
    cyc(); #1; chk("lw_memwb", 8'(d1_state), 8'd4);
    chk("lw_memwb_rw", 8'(d1_RegWrite), 8'd1);
    chk("lw_memwb_m2r", 8'(d1_MemtoReg), 8'd1);
    chk("lw_done_c5", 8'(d1_done), 8'd1);
    cyc(); #1; chk("lw_back_fetch", 8'(d1_state), 8'd0);
    op = OP_RTYPE; funct = FN_SLT;
    cyc();
    cyc(); #1; chk("slt_execute", 8'(d1_state), 8'd6);
    chk("slt_aluctl", 8'(d1_ALUControl), 8'b111);
    cyc(); #1; chk("slt_regdst", 8'(d1_RegDst), 8'd1);
    chk("slt_regwrite", 8'(d1_RegWrite), 8'd1);
    cyc(); op = OP_BEQ; zero = 1'b1;
    cyc();
    cyc(); #1; chk("beq_state", 8'(d1_state), 8'd8);
    chk("beq_z1_pcen", 8'(d1_PCEn), 8'd1);
    zero = 1'b0; #1;
    chk("beq_z0_pcen", 8'(d1_PCEn), 8'd0);
    cyc(); op = OP_BNE; zero = 1'b0;
    cyc(); #1;
    chk("bne_dis_decode_done", 8'(d0_done), 8'd1);
    chk("bne_en_decode_done", 8'(d1_done), 8'd0);
    cyc(); #1;
    chk("bne_z0_pcen", 8'(d1_PCEn), 8'd1);
    chk("bne_en_branch", 8'(d1_state), 8'd8);
    chk("bne_dis_fetch", 8'(d0_state), 8'd0);
    cyc(); reset = 1'b0;
    cyc(); reset = 1'b1; op = 6'b111111;
    cyc(); #1;
    chk("unk_decode", 8'(d1_state), 8'd1);
    chk("unk_done", 8'(d1_done), 8'd1);
    chk("unk_writes", 8'({d1_IRWrite, d1_MemWrite, d1_RegWrite, d1_PCEn}), 8'd0);
    cyc(); #1; chk("unk_fetch", 8'(d1_state), 8'd0);
    op = OP_SW;
    cyc(); cyc();
    cyc(); #1; chk("sw_memwr", 8'(d1_state), 8'd5);
    chk("sw_memwrite", 8'(d1_MemWrite), 8'd1);
    reset = 1'b0; #1;
    chk("sw_rst_memwrite", 8'(d1_MemWrite), 8'd0);
    chk("sw_rst_pcen", 8'(d1_PCEn), 8'd0);
    cyc(); #1; chk("sw_rst_fetch", 8'(d1_state), 8'd0);
    reset = 1'b1;

    // randomized instruction stream
    for (int i = 0; i < 3000; i++) begin
      cyc();
      zero = 1'($urandom_range(0, 1));
      if (pos0 == 0 && pos1 == 0) begin
        int k;
        k = int'($urandom_range(0, 7));
        op = (k < 7) ? op_tab[k] : 6'($urandom_range(0, 63));
        k = int'($urandom_range(0, 5));
        funct = (k < 5) ? fn_tab[k] : 6'($urandom_range(0, 63));
        if (!reset) reset = 1'b1;
      end
      if (reset && $urandom_range(0, 39) == 0) reset = 1'b0;
    end
    cyc();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
